// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the imem boot loader.
// Optional trailing checksum byte: LOADER_CSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_e;

  localparam int IMEM_DEPTH_DEFAULT = 64;
  localparam int HDR_MAX            = 255;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles four stream bytes into one little-endian 32-bit word.
// word_full flags the byte that completes the current word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;

  assign word      = r_word;
  assign word_full = byte_en && (r_idx == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (clear) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (byte_en) begin
      r_word[{r_idx, 3'b000} +: 8] <= byte_data;
      r_idx                        <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a byte-streamed image into imem, stalling the core until done.
// Define LOADER_CSUM_EN to require a trailing XOR checksum byte.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          core_stall,
  output logic          done,
  output logic          error
);

  state_e        r_state;
  logic [7:0]    r_n;
  logic [AW:0]   r_wcnt;
  logic [AW-1:0] r_waddr;
  logic [31:0]   r_wdata;
`ifdef LOADER_CSUM_EN
  logic [7:0]    r_csum;
`endif

  logic          w_take;
  logic          w_pack_en;
  logic          w_full;
  logic          w_hdr_bad;
  logic          w_last;
  logic [31:0]   w_word;
  logic [AW:0]   w_wcnt_nx;

  assign byte_ready = (r_state == HDR) ||
                      (r_state == DATA) ||
                      (r_state == CSUM);
  // start wins over a byte offered in the same cycle
  assign w_take     = byte_valid && byte_ready && !start;
  assign w_pack_en  = w_take && (r_state == DATA);
  assign w_hdr_bad  = (byte_data == 8'd0) ||
                      (int'(byte_data) > DEPTH);
  assign w_wcnt_nx  = r_wcnt + (AW+1)'(1);
  assign w_last     = int'(w_wcnt_nx) == int'(r_n);

  assign imem_we    = (r_state == WRITE);
  assign imem_waddr = imem_we ? r_wcnt[AW-1:0] : r_waddr;
  assign imem_wdata = imem_we ? w_word : r_wdata;
  assign done       = (r_state == DONE);
  assign error      = (r_state == ERR);
  assign core_stall = (r_state != DONE);

  imem_word_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (start),
    .byte_en   (w_pack_en),
    .byte_data (byte_data),
    .word      (w_word),
    .word_full (w_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_n     <= 8'd0;
      r_wcnt  <= '0;
      r_waddr <= '0;
      r_wdata <= 32'd0;
`ifdef LOADER_CSUM_EN
      r_csum  <= 8'd0;
`endif
    end else if (start) begin
      r_state <= HDR;
      r_wcnt  <= '0;
`ifdef LOADER_CSUM_EN
      r_csum  <= 8'd0;
`endif
    end else begin
      unique case (r_state)
        HDR: begin
          if (w_take) begin
            if (w_hdr_bad) begin
              r_state <= ERR;
            end else begin
              r_n     <= byte_data;
              r_wcnt  <= '0;
              r_state <= DATA;
`ifdef LOADER_CSUM_EN
              r_csum  <= byte_data;
`endif
            end
          end
        end
        DATA: begin
`ifdef LOADER_CSUM_EN
          if (w_take) r_csum <= r_csum ^ byte_data;
`endif
          if (w_full) r_state <= WRITE;
        end
        WRITE: begin
          r_waddr <= r_wcnt[AW-1:0];
          r_wdata <= w_word;
          r_wcnt  <= w_wcnt_nx;
`ifdef LOADER_CSUM_EN
          r_state <= w_last ? CSUM : DATA;
`else
          r_state <= w_last ? DONE : DATA;
`endif
        end
`ifdef LOADER_CSUM_EN
        CSUM: begin
          if (w_take) begin
            r_state <= (byte_data == r_csum) ? DONE : ERR;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader (byte-count reference model).
// Honours LOADER_CSUM_EN to match the DUT build.
module tb_imem_boot_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'd0;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_stall;
  logic          done;
  logic          error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_stall (core_stall),
    .done       (done),
    .error      (error)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: everything derives from the bytes accepted since start.
`ifdef LOADER_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  bit            m_started = 1'b0;
  logic [7:0]    rxq[$];
  bit            m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_data = 32'd0;
  bit            m_cerr = 1'b0;

  always @(negedge clk) begin
    bit e_err, e_done, e_rdy;
    int n, nd;
    logic [7:0] x;
    if (!reset_n) begin
      m_started = 1'b0;
      rxq.delete();
      m_wr   = 1'b0;
      m_addr = '0;
      m_data = 32'd0;
      m_cerr = 1'b0;
    end
    n  = (rxq.size() > 0) ? int'(rxq[0]) : 0;
    nd = (rxq.size() > 0) ? rxq.size() - 1 : 0;
    e_err  = m_cerr || (rxq.size() > 0 && (n == 0 || n > DEPTH));
    e_done = m_started && !e_err && !m_wr && rxq.size() > 0 &&
             nd == 4 * n + CS;
    e_rdy  = m_started && !e_err && !e_done && !m_wr;
    chk("byte_ready", 32'(byte_ready), 32'(e_rdy));
    chk("imem_we", 32'(imem_we), 32'(m_wr));
    chk("imem_waddr", 32'(imem_waddr), 32'(m_addr));
    chk("imem_wdata", imem_wdata, m_data);
    chk("done", 32'(done), 32'(e_done));
    chk("error", 32'(error), 32'(e_err));
    chk("core_stall", 32'(core_stall), 32'(!e_done));
    if (reset_n) begin
      if (start) begin
        m_started = 1'b1;
        rxq.delete();
        m_wr   = 1'b0;
        m_cerr = 1'b0;
      end else begin
        m_wr = 1'b0;
        if (byte_valid && e_rdy) begin
          rxq.push_back(byte_data);
          nd = rxq.size() - 1;
          n  = int'(rxq[0]);
          if (nd >= 1 && nd <= 4 * n && nd % 4 == 0) begin
            m_wr   = 1'b1;
            m_addr = AW'(nd / 4 - 1);
            m_data = {rxq[nd], rxq[nd-1], rxq[nd-2], rxq[nd-3]};
          end
          if (CS == 1 && nd == 4 * n + 1) begin
            x = 8'd0;
            for (int i = 0; i < nd; i++) x = x ^ rxq[i];
            if (x != byte_data) m_cerr = 1'b1;
          end
        end
      end
    end
  end

  // Log of observed writes for literal checks.
  int          wl_n = 0;
  logic [31:0] wl_addr[64];
  logic [31:0] wl_data[64];
  always @(negedge clk) begin
    if (imem_we && wl_n < 64) begin
      wl_addr[wl_n] = 32'(imem_waddr);
      wl_data[wl_n] = imem_wdata;
      wl_n++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    byte_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int guard;
    for (int i = 0; i < gap; i++) begin
      byte_valid = 1'b0;
      step();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    while (!byte_ready && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout act=%0d exp=<50", guard);
    end
    step();
    byte_valid = 1'b0;
  endtask

  logic [7:0] img[$];

  // Sends img; thr alternates 0/2 idle cycles between bytes.
  task automatic send_img(input bit thr);
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < img.size(); i++) begin
      send(img[i], (thr && i % 2 == 1) ? 2 : 0);
      x = x ^ img[i];
    end
    if (CS == 1) send(x, 0);
  endtask

  int base;

  initial begin
    #1;
    step();
    chk("rst_stall", 32'(core_stall), 32'd1);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    reset_n = 1'b1;
    step();

    // Nominal load
    base = wl_n;
    pulse_start();
    img = '{8'h02, 8'h37, 8'hA4, 8'h03, 8'h00,
            8'h13, 8'h04, 8'h04, 8'h7D};
    send_img(1'b0);
    if (CS == 0) begin
      chk("nom_we_after_last", 32'(imem_we), 32'd1);
      chk("nom_done_early", 32'(done), 32'd0);
      step();
    end
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_stall", 32'(core_stall), 32'd0);
    chk("nom_nwr", 32'(wl_n - base), 32'd2);
    chk("nom_a0", wl_addr[base], 32'd0);
    chk("nom_d0", wl_data[base], 32'h0003A437);
    chk("nom_a1", wl_addr[base+1], 32'd1);
    chk("nom_d1", wl_data[base+1], 32'h7D040413);
    step();

    // Throttled stream
    base = wl_n;
    pulse_start();
    send_img(1'b1);
    step();
    chk("thr_done", 32'(done), 32'd1);
    chk("thr_nwr", 32'(wl_n - base), 32'd2);
    chk("thr_d0", wl_data[base], 32'h0003A437);
    chk("thr_d1", wl_data[base+1], 32'h7D040413);

    // Bad headers
    base = wl_n;
    pulse_start();
    send(8'h00, 0);
    step();
    chk("hdr0_err", 32'(error), 32'd1);
    chk("hdr0_stall", 32'(core_stall), 32'd1);
    pulse_start();
    chk("restart_clr_err", 32'(error), 32'd0);
    send(8'h41, 0);
    step();
    chk("hdr41_err", 32'(error), 32'd1);
    chk("hdr_nwr", 32'(wl_n - base), 32'd0);
    pulse_start();
    send(8'h40, 0);
    step();
    chk("hdr40_ok", 32'(error), 32'd0);

    // Abort mid-word, then a fresh image
    base = wl_n;
    pulse_start();
    send(8'h02, 0);
    send(8'h37, 0);
    send(8'hA4, 0);
    send(8'h03, 0);
    pulse_start();
    img = '{8'h01, 8'h93, 8'h00, 8'h40, 8'h00};
    send_img(1'b0);
    step();
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_nwr", 32'(wl_n - base), 32'd1);
    chk("abort_a0", wl_addr[base], 32'd0);
    chk("abort_d0", wl_data[base], 32'h00400093);

    // Reset mid-load
    base = wl_n;
    pulse_start();
    send(8'h02, 0);
    send(8'h37, 0);
    send(8'hA4, 0);
    reset_n = 1'b0;
    #1;
    chk("rstmid_ready", 32'(byte_ready), 32'd0);
    chk("rstmid_stall", 32'(core_stall), 32'd1);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_wdata", imem_wdata, 32'd0);
    step();
    reset_n = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h03;
    for (int i = 0; i < 8; i++) step();
    byte_valid = 1'b0;
    chk("rstmid_nwr", 32'(wl_n - base), 32'd0);

`ifdef LOADER_CSUM_EN
    // Checksum accept and reject
    pulse_start();
    send(8'h01, 0);
    send(8'h13, 0);
    send(8'h04, 0);
    send(8'h04, 0);
    send(8'h7D, 0);
    send(8'h6F, 0);
    chk("csum_ok_done", 32'(done), 32'd1);
    pulse_start();
    send(8'h01, 0);
    send(8'h13, 0);
    send(8'h04, 0);
    send(8'h04, 0);
    send(8'h7D, 0);
    send(8'h00, 0);
    chk("csum_bad_err", 32'(error), 32'd1);
    chk("csum_bad_done", 32'(done), 32'd0);
`endif

    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
